// File: rtl/bc_pkg.sv
// Shared Bulls and Cows definitions: digit geometry, scorer state encoding
// and the guess legality check used by the answer and guess paths.
package bc_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;
  localparam logic [DIGIT_W-1:0] INVALID_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    REPORT  = 3'd2,
    WON     = 3'd3,
    LOST    = 3'd4
  } scorer_state_t;

  // A guess is legal when every nibble is a decimal digit and no digit repeats.
  function automatic logic is_legal_guess(input logic [DIGIT_W*NUM_DIGITS-1:0] g);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (g[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (g[i*DIGIT_W +: DIGIT_W] == g[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/digit_match.sv
// Classifies one guess digit at a given position against the whole answer:
// bull if it matches the answer digit at that position, cow if it matches another.
module digit_match
  import bc_pkg::*;
(
  input  logic [DIGIT_W-1:0]            g_digit,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] answer,
  input  logic [IDX_W-1:0]              pos,
  output logic                          is_bull,
  output logic                          is_cow
);

  logic same_pos;
  logic other_pos;

  always_comb begin
    same_pos  = 1'b0;
    other_pos = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      // digit0 lives in the most significant nibble
      if (answer[DIGIT_W*(NUM_DIGITS-1-i) +: DIGIT_W] == g_digit) begin
        if (i == int'(pos)) same_pos  = 1'b1;
        else                other_pos = 1'b1;
      end
    end
    is_bull = same_pos;
    is_cow  = other_pos & ~same_pos;
  end

endmodule

// File: rtl/guess_scorer.sv
// Bulls and Cows guess scorer: latches a guess and the secret answer, walks the
// four guess digits serially, then reports bulls/cows and tracks round and game state.
module guess_scorer
  import bc_pkg::*;
#(
  parameter int MAX_ROUNDS = 10
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [15:0] answer,
  input  logic        answer_valid,
  input  logic [15:0] guess,
  input  logic        guess_valid,
  input  logic        new_game,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  bulls,
  output logic [2:0]  cows,
  output logic [3:0]  round_cnt,
  output logic        win,
  output logic        game_over
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  scorer_state_t     state;
  logic [15:0]       guess_q;
  logic [15:0]       answer_q;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        bull_acc;
  logic [2:0]        cow_acc;
  logic              err_q;

  logic [DIGIT_W-1:0] g_digit;
  logic               is_bull;
  logic               is_cow;
  logic [3:0]         round_next;

  assign g_digit    = guess_q[DIGIT_W*(NUM_DIGITS-1-int'(idx)) +: DIGIT_W];
  assign round_next = round_cnt + 4'd1;

  digit_match u_digit_match (
    .g_digit (g_digit),
    .answer  (answer_q),
    .pos     (idx),
    .is_bull (is_bull),
    .is_cow  (is_cow)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      guess_q   <= '0;
      answer_q  <= '0;
      idx       <= '0;
      bull_acc  <= '0;
      cow_acc   <= '0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bulls     <= '0;
      cows      <= '0;
      round_cnt <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (new_game) begin
        // Restart drops any in-flight compare without reporting it
        state     <= IDLE;
        busy      <= 1'b0;
        bulls     <= '0;
        cows      <= '0;
        round_cnt <= '0;
        win       <= 1'b0;
        game_over <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (guess_valid && answer_valid) begin
              guess_q  <= guess;
              answer_q <= answer;
              bull_acc <= '0;
              cow_acc  <= '0;
              idx      <= '0;
              if (is_legal_guess(guess)) begin
                err_q <= 1'b0;
                busy  <= 1'b1;
                state <= COMPARE;
              end else begin
                err_q <= 1'b1;
                state <= REPORT;
              end
            end
          end
          COMPARE: begin
            bull_acc <= bull_acc + {2'b00, is_bull};
            cow_acc  <= cow_acc + {2'b00, is_cow};
            idx      <= idx + 1'b1;
            if (idx == IDX_W'(NUM_DIGITS - 1)) state <= REPORT;
          end
          REPORT: begin
            done <= 1'b1;
            busy <= 1'b0;
            if (err_q) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              bulls     <= bull_acc;
              cows      <= cow_acc;
              round_cnt <= round_next;
              if (bull_acc == 3'd4) begin
                win       <= 1'b1;
                game_over <= 1'b1;
                state     <= WON;
              end else if (round_next == MAX_R) begin
                game_over <= 1'b1;
                state     <= LOST;
              end else begin
                state <= IDLE;
              end
            end
          end
          WON, LOST: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/guess_scorer.md
# guess_scorer

Scores a player's four-digit guess against the stored secret answer for the Bulls and Cows game. It consumes the 16-bit packed answer and its legal flag produced by the answer-entry block, accepts one guess per request, and reports bulls, cows, round count and win/lose status. Comparison runs serially over the four guess digits with a start/done handshake. The block sits between guess entry and the result display.

## Interface
- MAX_ROUNDS, 10, number of legal guesses allowed before the game is lost (1..15)
- CLK  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- answer  in  16  secret; digit0 = [15:12] (first entered) .. digit3 = [3:0], BCD per nibble
- answer_valid  in  1  high when answer holds no 4'hF nibble
- guess  in  16  guess, same packing as answer
- guess_valid  in  1  request to score guess; sampled only in IDLE
- new_game  in  1  synchronous restart, highest priority after reset
- busy  out  1  comparison in progress
- done  out  1  one-cycle pulse: result outputs updated
- err  out  1  one-cycle pulse with done: guess rejected
- bulls  out  3  correct digit, correct position (0..4)
- cows  out  3  correct digit, wrong position (0..4)
- round_cnt  out  4  legal guesses scored this game
- win  out  1  sticky: last scored guess had bulls = 4
- game_over  out  1  sticky: won or rounds exhausted

## Operation
- States: IDLE, COMPARE, REPORT, WON, LOST.
- IDLE: guess_valid=1 and answer_valid=1 -> latch guess and answer into internal registers. If guess is legal, clear accumulators, idx=0, go COMPARE. Otherwise go REPORT with an error flag set. guess_valid while answer_valid=0 is ignored.
- Legal guess: every nibble <= 9 and all four digits distinct.
- COMPARE: one digit per cycle, idx 0..3. Guess digit idx equal to latched answer digit idx -> bull+1. Otherwise, equal to any other answer digit -> cow+1. After idx=3 go REPORT.
- REPORT (one cycle):
  - Error path: pulse done and err; bulls, cows and round_cnt unchanged; return to IDLE.
  - Legal path: load bulls/cows, round_cnt+1, pulse done.
  - Next state: bulls=4 -> WON (win=1, game_over=1). Else new round_cnt = MAX_ROUNDS -> LOST (game_over=1). Else IDLE.
- WON/LOST: all guess_valid ignored until new_game.
- new_game: any state -> IDLE. Clears bulls, cows, round_cnt, win, game_over, busy. An in-flight compare is aborted and no done is issued.
- Answer changes after latch do not affect the current compare.
- Width rule: bull and cow counters are 3 bits and saturate by construction (at most 4).

## Timing
- Reset: all outputs 0, state IDLE, internal registers 0.
- Legal guess accepted at edge E0:
  - busy=1 from E0 to E4.
  - COMPARE runs at edges E1..E4.
  - REPORT at E5 updates bulls/cows/round_cnt/win/game_over, asserts done and clears busy.
  - done cleared at E6.
  - Latency from accept to done: 5 cycles.
- Illegal guess accepted at E0: REPORT at E1 asserts done and err; both cleared at E2; busy never asserted.
- guess_valid may be held high. A new request is accepted no earlier than the first IDLE edge after done.
- new_game and guess_valid on the same edge: new_game wins and the guess is dropped.
- Reset mid-compare: immediate return to reset values; no done.

## Structure
- Shared package bc_pkg:
  - DIGIT_W=4, NUM_DIGITS=4, INVALID_DIGIT=4'hF.
  - State enum for this block.
  - Function: legal-guess check (range + distinct).
- Sub-module digit_match (combinational): inputs guess digit, answer vector and position; outputs is_bull and is_cow. Instantiated once and indexed by idx.

## Test plan
- Exact match: answer 16'h1234, guess 16'h1234 -> done 5 cycles after accept, bulls=4, cows=0, round_cnt=1, win=1, game_over=1; a further guess is ignored.
- Mixed scoring, in turn: guess 4321 -> 0/4; guess 1256 -> 2/0; guess 5612 -> 0/2; guess 1243 -> 2/2. round_cnt reaches 4.
- Illegal guesses 16'h12F4 and 16'h1123 -> done+err 1 cycle after accept, bulls/cows/round_cnt unchanged, busy stays 0.
- MAX_ROUNDS=10: ten guesses of 5678 vs 1234 -> each 0/0; after the tenth, game_over=1, win=0; an eleventh guess is ignored.
- Abort cases: new_game asserted at E2 of a compare -> no done, all outputs 0, IDLE. rst_n low at E3 -> same result, asynchronously.
- answer_valid=0 with guess_valid=1 for 3 cycles -> no busy, no done.
